// File: rtl/check_sched_pkg.sv
// rtl/check_sched_pkg.sv - shared state type and count width for the check scheduler
package check_sched_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } sched_state_t;

endpackage

// File: rtl/check_scheduler_if.sv
// rtl/check_scheduler_if.sv - compare request bus: per-requester valid/operands, one-hot ready back
interface check_scheduler_if #(
   parameter int N_REQ       = 4,
   parameter int CHECK_WIDTH = 32
) ();

   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ*CHECK_WIDTH-1:0] req_value;
   logic [N_REQ*CHECK_WIDTH-1:0] req_expected;
   logic [N_REQ-1:0]             req_ready;

   modport master (
      output req_valid, req_value, req_expected,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_value, req_expected,
      output req_ready
   );

endinterface

// File: rtl/check_rr_arbiter.sv
// rtl/check_rr_arbiter.sv - round-robin one-hot grant; pointer moves past the winner on every grant
module check_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant
);

   localparam int PW = $clog2(N_REQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic          found;

   // req is already qualified by the caller, so any grant is an accepted transfer
   always_comb begin
      grant = '0;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = PW'((int'(ptr) + off) % N_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (found) grant[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
   end

endmodule

// File: rtl/check_scheduler.sv
// rtl/check_scheduler.sv - arbitrated compare engine with run FSM, watchdog and counters
// Optional error capture log: CHECK_SCHED_ERRLOG_EN
module check_scheduler
   import check_sched_pkg::*;
#(
   parameter int CHECK_WIDTH   = 32,
   parameter int N_REQ         = 4,
   parameter int ERR_THRESHOLD = 100,
   parameter int WD_WIDTH      = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   finish,
   input  logic                   wd_load,
   input  logic [WD_WIDTH-1:0]    wd_cycles,
   check_scheduler_if.slave       req_if,
   output logic [CNT_W-1:0]       num_checks,
   output logic [CNT_W-1:0]       num_errors,
   output logic                   err_pulse,
   output logic                   trunc,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic                   err_log_valid,
   output logic [2:0]             err_src,
   output logic [CHECK_WIDTH-1:0] err_value,
   output logic [CHECK_WIDTH-1:0] err_expected
);

   localparam logic [CNT_W-1:0] THR = CNT_W'(ERR_THRESHOLD);

   sched_state_t          state;
   logic [WD_WIDTH-1:0]   wd_cnt;
   logic [N_REQ-1:0]      arb_req;
   logic [N_REQ-1:0]      grant;
   logic                  accept;
   logic                  mismatch;
   logic                  hit_thr;
   logic                  expire;
   logic [CHECK_WIDTH-1:0] acc_value;
   logic [CHECK_WIDTH-1:0] acc_expected;

   // a start cycle restarts the run, so nothing is accepted into the old one
   assign arb_req = (state == ST_RUN && !start) ? req_if.req_valid : '0;

   check_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (arb_req),
      .grant (grant)
   );

   assign req_if.req_ready = grant;
   assign accept           = |grant;
   assign busy             = (state == ST_RUN) || (state == ST_DRAIN);

   always_comb begin
      acc_value    = '0;
      acc_expected = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            acc_value    = req_if.req_value[i*CHECK_WIDTH +: CHECK_WIDTH];
            acc_expected = req_if.req_expected[i*CHECK_WIDTH +: CHECK_WIDTH];
         end
      end
   end

   assign mismatch = accept && (acc_value != acc_expected);
   assign hit_thr  = mismatch && (num_errors != '1) && (num_errors + CNT_W'(1) == THR);
   assign expire   = (state == ST_RUN) && (wd_cnt == WD_WIDTH'(1)) && !wd_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wd_cnt     <= '0;
         num_checks <= '0;
         num_errors <= '0;
         err_pulse  <= 1'b0;
         trunc      <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         if (wd_load) begin
            wd_cnt <= wd_cycles;
         end else if (state == ST_RUN && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
         end

         if (start) begin
            state      <= ST_RUN;
            num_checks <= '0;
            num_errors <= '0;
            err_pulse  <= 1'b0;
            trunc      <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
         end else begin
            // compare stage: result of this cycle's transfer is visible next cycle
            err_pulse <= mismatch;
            if (accept && num_checks != '1) num_checks <= num_checks + 1'b1;
            if (mismatch && num_errors != '1) num_errors <= num_errors + 1'b1;
            if (hit_thr) trunc <= 1'b1;

            case (state)
               ST_RUN: begin
                  if (finish) begin
                     state <= ST_DRAIN;
                  end else if (expire) begin
                     state   <= ST_DRAIN;
                     timeout <= 1'b1;
                  end
               end
               ST_DRAIN: begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  pass  <= (num_errors == '0) && !timeout;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CHECK_SCHED_ERRLOG_EN
   logic [2:0] acc_src;
   logic       log_now;

   always_comb begin
      acc_src = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) acc_src = 3'(i);
      end
   end

   // the error that reaches the threshold is already beyond the log
   assign log_now = mismatch && !trunc && !hit_thr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_log_valid <= 1'b0;
         err_src       <= '0;
         err_value     <= '0;
         err_expected  <= '0;
      end else begin
         err_log_valid <= log_now;
         if (log_now) begin
            err_src      <= acc_src;
            err_value    <= acc_value;
            err_expected <= acc_expected;
         end
      end
   end
`else
   assign err_log_valid = 1'b0;
   assign err_src       = '0;
   assign err_value     = '0;
   assign err_expected  = '0;
`endif

endmodule

// File: tb/tb_check_scheduler.sv
// tb/tb_check_scheduler.sv - scoreboard bench for check_scheduler with a cycle model of the run
module tb_check_scheduler;
   import check_sched_pkg::*;

   localparam int CW = 32, NR = 4, THR = 100, WDW = 32;

   logic           clk = 1'b0, rst_n = 1'b1, start = 1'b0, finish = 1'b0, wd_load = 1'b0;
   logic [WDW-1:0] wd_cycles = '0;
   logic [31:0]    num_checks, num_errors;
   logic           err_pulse, trunc, busy, done, pass, timeout, err_log_valid;
   logic [2:0]     err_src;
   logic [CW-1:0]  err_value, err_expected;

   check_scheduler_if #(.N_REQ(NR), .CHECK_WIDTH(CW)) req_if ();

   check_scheduler #(.CHECK_WIDTH(CW), .N_REQ(NR), .ERR_THRESHOLD(THR), .WD_WIDTH(WDW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .wd_load(wd_load),
      .wd_cycles(wd_cycles), .req_if(req_if), .num_checks(num_checks), .num_errors(num_errors),
      .err_pulse(err_pulse), .trunc(trunc), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .err_log_valid(err_log_valid), .err_src(err_src),
      .err_value(err_value), .err_expected(err_expected)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            err;
      bit            logged;
      logic [2:0]    src;
      logic [CW-1:0] val;
      logic [CW-1:0] expv;
   } sb_t;

   sb_t sb_q[$];

   int n_checks = 0, n_errors = 0, log_cnt = 0;

   sched_state_t   m_state = ST_IDLE;
   int             m_ptr = 0;
   logic [31:0]    m_checks = '0, m_errors = '0;
   bit             m_trunc = 0, m_done = 0, m_pass = 0, m_timeout = 0;
   logic [WDW-1:0] m_wd = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = ST_IDLE; m_ptr = 0; m_checks = '0; m_errors = '0;
      m_trunc = 0; m_done = 0; m_pass = 0; m_timeout = 0; m_wd = '0;
      sb_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_checks"}, num_checks, 0);
      check_eq({tag, "_errors"}, num_errors, 0);
      check_eq({tag, "_errp"}, err_pulse, 0);
      check_eq({tag, "_trunc"}, trunc, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_pass"}, pass, 0);
      check_eq({tag, "_timeout"}, timeout, 0);
      check_eq({tag, "_ready"}, req_if.req_ready, 0);
      check_eq({tag, "_logv"}, err_log_valid, 0);
      check_eq({tag, "_src"}, err_src, 0);
      check_eq({tag, "_val"}, err_value, 0);
      check_eq({tag, "_exp"}, err_expected, 0);
   endtask

   // entered at posedge+1 with inputs set; returns at the next posedge+1
   task automatic step();
      logic [NR-1:0] eg;
      int            win;
      bit            mis, expire;
      sched_state_t  st0;
      sb_t           e;
      eg = '0; win = -1; mis = 0;
      #1;
      st0 = m_state;
      if (m_state == ST_RUN && !start)
         for (int k = 0; k < NR; k++)
            if (win < 0 && req_if.req_valid[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      if (win >= 0) eg[win] = 1'b1;
      check_eq("req_ready", req_if.req_ready, eg);
      if (win >= 0) begin
         e.val    = req_if.req_value[win*CW +: CW];
         e.expv   = req_if.req_expected[win*CW +: CW];
         mis      = (e.val != e.expv);
         e.err    = mis;
         e.logged = mis && !m_trunc && (m_errors + 1 != THR);
         e.src    = 3'(win);
         sb_q.push_back(e);
         m_ptr = (win + 1) % NR;
      end
      expire = (st0 == ST_RUN) && (m_wd == 1) && !wd_load;
      if (wd_load) m_wd = wd_cycles;
      else if (st0 == ST_RUN && m_wd != 0) m_wd = m_wd - 1;
      if (start) begin
         m_state = ST_RUN; m_checks = '0; m_errors = '0;
         m_trunc = 0; m_done = 0; m_pass = 0; m_timeout = 0;
      end else begin
         if (win >= 0) begin
            m_checks++;
            if (mis) begin
               m_errors++;
               if (m_errors == THR) m_trunc = 1;
            end
         end
         case (st0)
            ST_RUN:   if (finish) m_state = ST_DRAIN;
                      else if (expire) begin m_state = ST_DRAIN; m_timeout = 1; end
            ST_DRAIN: begin m_state = ST_DONE; m_done = 1; m_pass = (m_errors == 0) && !m_timeout; end
            default: ;
         endcase
      end
      @(posedge clk); #1;
      start = 0; finish = 0; wd_load = 0;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq("err_pulse", err_pulse, e.err);
`ifdef CHECK_SCHED_ERRLOG_EN
         check_eq("err_log_valid", err_log_valid, e.logged);
         if (e.logged) begin
            check_eq("err_src", err_src, e.src);
            check_eq("err_value", err_value, e.val);
            check_eq("err_expected", err_expected, e.expv);
         end
`else
         check_eq("err_log_valid", err_log_valid, 0);
`endif
      end else begin
         check_eq("err_pulse_idle", err_pulse, 0);
         check_eq("err_log_idle", err_log_valid, 0);
      end
      if (err_log_valid) log_cnt++;
      check_eq("num_checks", num_checks, m_checks);
      check_eq("num_errors", num_errors, m_errors);
      check_eq("trunc", trunc, m_trunc);
      check_eq("busy", busy, (m_state == ST_RUN) || (m_state == ST_DRAIN));
      check_eq("done", done, m_done);
      check_eq("pass", pass, m_pass);
      check_eq("timeout", timeout, m_timeout);
   endtask

   task automatic set_req(input int k, input logic [CW-1:0] v, input logic [CW-1:0] x);
      req_if.req_value[k*CW +: CW]    = v;
      req_if.req_expected[k*CW +: CW] = x;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int cnt;
      logic [CW-1:0] v;
      req_if.req_valid = '0; req_if.req_value = '0; req_if.req_expected = '0;
      #2 rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1;
      model_reset();

      // equal operands from all requesters: strict 0,1,2,3,0 rotation
      start = 1; step();
      req_if.req_valid = 4'hF;
      for (int k = 0; k < NR; k++) set_req(k, CW'(k * 7 + 1), CW'(k * 7 + 1));
      repeat (8) step();
      req_if.req_valid = '0; finish = 1; step(); step();
      check_eq("a_done", done, 1);
      check_eq("a_pass", pass, 1);
      check_eq("a_checks", num_checks, 8);

      // single mismatch on requester 2
      start = 1; step();
      req_if.req_valid = 4'b0100; set_req(2, 32'h0000_00FF, 32'h0000_00FE);
      step();
      req_if.req_valid = '0; step();
      finish = 1; step(); step();
      check_eq("b_errors", num_errors, 1);
      check_eq("b_pass", pass, 0);
`ifdef CHECK_SCHED_ERRLOG_EN
      check_eq("b_src", err_src, 2);
`endif

      // drive random traffic until 101 mismatches have been accepted
      start = 1; step();
      log_cnt = 0; cnt = 0;
      while (m_errors < 101 && cnt < 3000) begin
         req_if.req_valid = NR'($urandom_range(1, 15));
         for (int k = 0; k < NR; k++) begin
            v = $urandom;
            set_req(k, v, $urandom_range(0, 1) ? v : v ^ (CW'(1) << $urandom_range(0, 31)));
         end
         step(); cnt++;
      end
      req_if.req_valid = '0; step();
      check_eq("c_errors", num_errors, 101);
      check_eq("c_trunc", trunc, 1);
`ifdef CHECK_SCHED_ERRLOG_EN
      check_eq("c_log_cnt", log_cnt, 99);
`else
      check_eq("c_log_cnt", log_cnt, 0);
`endif
      finish = 1; step(); step();
      check_eq("c_pass", pass, 0);

      // watchdog expiry without finish
      start = 1; step();
      wd_cycles = 10; wd_load = 1; step();
      cnt = 0;
      while (!timeout && cnt < 30) begin step(); cnt++; end
      check_eq("d_expiry_cycles", cnt, 10);
      check_eq("d_done_early", done, 0);
      step();
      check_eq("d_done", done, 1);
      check_eq("d_pass", pass, 0);

      // finish on the expiry cycle wins
      start = 1; step();
      wd_cycles = 5; wd_load = 1; step();
      cnt = 0;
      while (m_wd != 1 && cnt < 20) begin step(); cnt++; end
      finish = 1; step();
      check_eq("e_timeout", timeout, 0);
      step();
      check_eq("e_pass", pass, 1);

      // reload on the expiry cycle keeps the run going
      start = 1; step();
      wd_cycles = 5; wd_load = 1; step();
      cnt = 0;
      while (m_wd != 1 && cnt < 20) begin step(); cnt++; end
      wd_cycles = 7; wd_load = 1; step();
      check_eq("f_timeout", timeout, 0);
      check_eq("f_busy", busy, 1);
      cnt = 0;
      while (!timeout && cnt < 30) begin step(); cnt++; end
      check_eq("f_expiry_cycles", cnt, 7);
      step();

      // reset with a transfer in flight
      start = 1; step();
      req_if.req_valid = 4'b0100; set_req(2, 32'h1234, 32'h4321);
      #2;
      check_eq("g_inflight_ready", req_if.req_ready, 4'b0100);
      rst_n = 0; #1;
      check_all_zero("g_rst");
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      step(); step();
      check_eq("g_checks", num_checks, 0);
      req_if.req_valid = '0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/check_scheduler.md
CHECK_SCHEDULER -- requirements
Module: check_scheduler

Interface
REQ-001 SHALL have parameter CHECK_WIDTH, default 32, compare operand width.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter ERR_THRESHOLD, default 100, error count at which error logging truncates.
REQ-004 SHALL have parameter WD_WIDTH, default 32, watchdog counter width.
REQ-005 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-006 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Ports: start  in  1  pulse; clears counters, enters RUN.
REQ-008 Ports: finish  in  1  pulse; ends run (wrap-up).
REQ-009 Ports: req_valid  in  N_REQ  per-requester compare request.
REQ-010 Ports: req_value, req_expected  in  N_REQ*CHECK_WIDTH  packed operands, requester i at slice i.
REQ-011 Ports: req_ready  out  N_REQ  one-hot grant; transfer when valid & ready.
REQ-012 Ports: wd_load  in  1  pulse; loads watchdog with wd_cycles.
REQ-013 Ports: wd_cycles  in  WD_WIDTH  watchdog period in clk cycles; 0 disables.
REQ-014 Ports: num_checks, num_errors  out  32  running counts.
REQ-015 Ports: err_pulse  out  1  one-cycle pulse per mismatch.
REQ-016 Ports: trunc  out  1  sticky; error logging disabled.
REQ-017 Ports: busy, done, pass, timeout  out  1 each  run status.
REQ-018 Ports: err_log_valid  out  1; err_src  out  3; err_value, err_expected  out  CHECK_WIDTH  (error log, see Configuration).

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on finish or watchdog expiry; DRAIN->DONE after one cycle; DONE->RUN on start.
REQ-020 start in any state SHALL clear counters, trunc, done, pass, timeout, compare stage and enter RUN next cycle.
REQ-021 req_ready SHALL be all-zero outside RUN; in RUN at most one bit set, to the round-robin winner among req_valid.
REQ-022 Round-robin SHALL search from (last granted index + 1) mod N_REQ; pointer resets to 0 so requester 0 wins first.
REQ-023 Accepted operands SHALL register in one compare stage; num_checks increments and err_pulse asserts exactly one cycle after acceptance.
REQ-024 Mismatch SHALL be bitwise inequality; num_errors increments on mismatch; both counters saturate at 2^32-1.
REQ-025 When num_errors becomes ERR_THRESHOLD, trunc SHALL set in the same cycle and hold until start/reset; err_log_valid SHALL not assert for that or later errors.
REQ-026 DRAIN SHALL let an in-flight compare complete so it is counted before done.
REQ-027 On entering DONE: done=1, pass=(num_errors==0 and timeout==0); held until start.
REQ-028 Watchdog SHALL decrement once per cycle in RUN while nonzero; transition 1->0 SHALL set timeout and force RUN->DRAIN.
REQ-029 wd_load SHALL reload the counter in any state; wd_load and expiry same cycle: load wins, no timeout.
REQ-030 finish and expiry same cycle: finish wins, timeout stays 0.
REQ-031 busy SHALL equal (state==RUN or state==DRAIN).

Reset
REQ-032 rst_n low SHALL immediately force IDLE, all counters/flags/outputs 0, arbiter pointer 0, watchdog 0.
REQ-033 Reset mid-run SHALL discard in-flight compare without counting it.

Configuration
REQ-034 Macro CHECK_SCHED_ERRLOG_EN defined: err_log_valid pulses with err_pulse while trunc==0, err_src/err_value/err_expected capture the mismatching requester and operands, held until next logged error.
REQ-035 Macro undefined: err_log_valid, err_src, err_value, err_expected tied to 0, no capture registers; all other behaviour identical.

Structure
REQ-036 Package check_sched_pkg SHALL hold the FSM state typedef and the 32-bit count width constant.
REQ-037 Round-robin grant logic SHALL be sub-module check_rr_arbiter (req in, grant out, pointer update on accept).

Verification
REQ-038 start; requesters 0..3 valid every cycle, all equal -> grants 0,1,2,3,0 in order; after finish, num_checks matches accepts, pass=1.
REQ-039 Requester 2 sends value 0x0000_00FF, expected 0x0000_00FE -> err_pulse one cycle after accept, num_errors=1, err_src=2 (macro on), pass=0.
REQ-040 Send 101 mismatches -> trunc sets at error 100, err_log_valid count=99, num_errors=101.
REQ-041 wd_load with wd_cycles=10, no finish -> timeout=1 and done 2 cycles after expiry, pass=0.
REQ-042 finish on the expiry cycle -> timeout=0; wd_load on expiry cycle -> counter reloaded, still RUN.
REQ-043 rst_n low for one cycle mid-run with a compare in flight -> all outputs 0 immediately, num_checks stays 0 after release.
